// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Round-robin arbiter/sequencer in front of a single-port memory.
//               Grants one requester command per cycle, registers it onto the
//               memory command port, and returns read data to the issuing
//               requester using an in-order owner FIFO.
//               Optional macro MEM_REQ_ARBITER_ADDR_CHECK_EN adds the err port
//               and blocks commands addressed at or beyond DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_REQ    = 2,
    parameter int MAX_OUT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MEM_REQ_ARBITER_ADDR_CHECK_EN
    output logic [NUM_REQ-1:0]            err,
`endif
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mem_en,
    output logic                          mem_wr,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic [DATA_WIDTH-1:0]         mem_data_out,
    input  logic                          mem_valid_out,
    output logic                          busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int PW   = $clog2(MAX_OUT);
    localparam logic [PW:0] c_ptr_one = 1;

    // Reject unsupported configurations at elaboration time.
    if (DEPTH < 1 || NUM_REQ < 2 || NUM_REQ > 8 || MAX_OUT < 2 ||
        (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_param_check
        $error("mem_req_arbiter: unsupported parameter combination");
    end

    // Owner FIFO: pointers carry one wrap bit to tell full from empty.
    logic [PW:0]            r_wptr, r_rptr;
    logic [IDXW-1:0]        r_owner [MAX_OUT];
    logic [IDXW-1:0]        r_last;

    logic                   r_mem_en, r_mem_wr;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_data_in;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_data;

    logic                   w_empty, w_full, w_pop, w_push, w_rd_block;
    logic [IDXW-1:0]        w_head;
    logic [NUM_REQ-1:0]     w_head_oh;
    logic [NUM_REQ-1:0]     w_elig, w_gnt;
    logic                   w_found, w_grant, w_bad;
    logic [IDXW-1:0]        w_sel;
    logic                   w_cmd_wr;
    logic [ADDR_WIDTH-1:0]  w_cmd_addr;
    logic [DATA_WIDTH-1:0]  w_cmd_wdata;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop   = mem_valid_out && !w_empty;
    assign w_head  = r_owner[r_rptr[PW-1:0]];
    // A pop in this cycle frees a slot, so a waiting read may go in the same cycle.
    assign w_rd_block = w_full && !w_pop;
    assign w_elig     = req & (req_wr | {NUM_REQ{~w_rd_block}});

    // Round-robin pick: first eligible above last_granted, else first eligible from 0.
    always_comb begin
        w_found     = 1'b0;
        w_sel       = '0;
        w_gnt       = '0;
        w_cmd_wr    = 1'b0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i] && (IDXW'(i) > r_last)) begin
                w_found  = 1'b1;
                w_sel    = IDXW'(i);
                w_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i]) begin
                w_found  = 1'b1;
                w_sel    = IDXW'(i);
                w_gnt[i] = 1'b1;
            end
        end
        if (rst) begin
            w_gnt = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_cmd_wr    = req_wr[i];
                w_cmd_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_cmd_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_grant = |w_gnt;

`ifdef MEM_REQ_ARBITER_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] c_depth = ADDR_WIDTH'(DEPTH);
    logic [NUM_REQ-1:0] r_err;

    assign w_bad = (w_cmd_addr >= c_depth);

    // Out-of-range grants are reported on err instead of reaching the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= (w_grant && w_bad) ? w_gnt : '0;
        end
    end

    assign err = r_err;
`else
    assign w_bad = 1'b0;
`endif

    assign w_push = w_grant && !w_cmd_wr && !w_bad;

    // Decode the FIFO head into the one-hot response strobe.
    always_comb begin
        w_head_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_head_oh[i] = (w_head == IDXW'(i));
        end
    end

    // Register the granted command onto the memory port; addr/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_mem_en <= w_grant && !w_bad;
            r_mem_wr <= w_grant && !w_bad && w_cmd_wr;
            if (w_grant && !w_bad) begin
                r_mem_addr    <= w_cmd_addr;
                r_mem_data_in <= w_cmd_wdata;
            end
        end
    end

    // Round-robin pointer; reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IDXW'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_last <= w_sel;
        end
    end

    // Owner FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_owner[r_wptr[PW-1:0]] <= w_sel;
        end
    end

    // Owner FIFO pointers; reset discards every outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Route returning read data to the oldest outstanding owner; orphans are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_pop) begin
                r_rsp_valid <= w_head_oh;
                r_rsp_data  <= mem_data_out;
            end
        end
    end

    assign gnt         = w_gnt;
    assign mem_en      = r_mem_en;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign busy        = !w_empty || r_mem_en;

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single-port memory between NUM_REQ requesters.
- Accepts per-requester read/write commands with a req/gnt handshake and drives the memory command port (en/wr/addr/data_in).
- Routes each memory read response (data_out/valid_out) back to the requester that issued it, using an in-order owner FIFO.
- Sits between the requester agents/masters and the memory macro.

Parameters:
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory data width
- DEPTH, 16, number of valid memory words; legal addresses are 0..DEPTH-1
- NUM_REQ, 2, number of requesters (2..8)
- MAX_OUT, 4, maximum outstanding reads; owner FIFO depth, power of two

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester command request
- req_wr  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
- gnt  output  NUM_REQ  combinational one-hot; command accepted this cycle
- rsp_valid  output  NUM_REQ  one-hot read response strobe
- rsp_data  output  DATA_WIDTH  read data, qualified by rsp_valid
- mem_en  output  1  memory enable
- mem_wr  output  1  memory write strobe
- mem_addr  output  ADDR_WIDTH  memory address
- mem_data_in  output  DATA_WIDTH  memory write data
- mem_data_out  input  DATA_WIDTH  memory read data
- mem_valid_out  input  1  memory read-data valid
- busy  output  1  owner FIFO non-empty or mem_en asserted

Behaviour:
- Reset (async): mem_en=0, mem_wr=0, mem_addr=0, mem_data_in=0, rsp_valid=0, rsp_data=0, busy=0. Owner FIFO is emptied and the RR pointer is set so that requester 0 has top priority.
- Eligibility: requester i is eligible when req[i]=1 and either req_wr[i]=1, or the owner FIFO is not full (a read pushed to a full FIFO would have nowhere to record its owner).
- Arbitration: round-robin among eligible requesters. Search starts at last_granted+1 and wraps modulo NUM_REQ. At most one gnt bit is set per cycle. gnt is 0 while rst=1.
- last_granted updates only on a cycle where a grant is issued. Ineligible requesters are skipped without losing their turn order.
- Command issue: a grant in cycle T registers mem_en=1, mem_wr=req_wr, mem_addr and mem_data_in, all visible in T+1. With no grant, mem_en=0 and mem_wr=0; addr/data hold their previous values.
- Owner tracking: a granted read pushes the requester index into the owner FIFO at T.
- Memory contract: mem_valid_out is asserted exactly once per read, in order, one cycle after mem_en (T+2).
- Response: on mem_valid_out, pop the FIFO head and register rsp_valid[head]=1 and rsp_data=mem_data_out, visible the next cycle (T+3). Read latency from gnt to rsp_valid is 3 cycles.
- Simultaneous push and pop in the same cycle is legal; FIFO occupancy is unchanged.
- Full FIFO: with MAX_OUT reads outstanding, all reads stall (no gnt) while writes are still granted. The stalled read is granted in the same cycle a pop frees a slot.
- Back-to-back: one command per cycle is sustainable, giving 100% memory utilisation when the FIFO is not full.
- Orphan response: mem_valid_out with an empty FIFO is ignored; no rsp_valid is generated.
- Reset mid-operation: all outstanding reads are discarded. Memory responses arriving after reset deasserts fall under the orphan rule.
- Requesters hold req and command fields stable until granted. The arbiter does not require this, but unstable fields yield an undefined command.

Optional Feature:
- Macro: MEM_REQ_ARBITER_ADDR_CHECK_EN
- When defined:
  - Adds output err, NUM_REQ bits.
  - A granted command with addr >= DEPTH does not drive mem_en (it stays 0 in T+1) and is not pushed to the owner FIFO.
  - err[i] pulses 1 in T+1 instead. For such a read, no rsp_valid is generated.
  - err resets to 0.
- When not defined: no err port, and all addresses are forwarded unchanged.

Test Plan:
- Single write then read (NUM_REQ=2, MAX_OUT=4):
  - Stimulus: requester 0 writes addr 3, data 0xA5A5_0001; then reads addr 3.
  - Required: gnt[0] in the request cycle; mem_en=1 and mem_wr=1 on the next cycle; rsp_valid[0]=1 with rsp_data=0xA5A5_0001 exactly 3 cycles after the read gnt.
- Contention: both requesters hold req (reads) continuously from reset.
  - Required: gnt sequence 01, 10, 01, 10…; rsp_valid follows the same alternation 3 cycles later, and each rsp_data matches that requester's address contents.
- FIFO full:
  - Stimulus: hold off mem_valid_out in the memory model; requester 0 issues 5 reads.
  - Required: first 4 granted, 5th gnt withheld; a concurrent requester 1 write is granted. The 5th read is granted in the cycle the first response pops.
- Reset mid-operation:
  - Stimulus: assert rst with 2 reads outstanding; the memory model then returns 2 mem_valid_out pulses after release.
  - Required: all outputs go to 0 immediately; no rsp_valid follows; the next request from requester 0 is granted first.
- Same-cycle push/pop: a steady stream of reads at full rate.
  - Required: occupancy stays at 2, there is no stall, and busy=1 throughout.
- Address check (MEM_REQ_ARBITER_ADDR_CHECK_EN defined, DEPTH=16):
  - Stimulus: requester 1 reads addr 16.
  - Required: gnt[1]=1; mem_en=0 and err[1]=1 next cycle; no rsp_valid. A following read of addr 15 completes normally.
